npc_btb: RTL

Next-PC generator for the pipelined RISC-V core; it sits directly upstream of the PC register and drives its NPC input every cycle. It predicts the fetch successor of the current PC with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters. It also corrects mispredictions resolved in EX, redirecting fetch and raising a flush. When a misprediction lands while the PC is held, it keeps the correction pending until the PC is released.

---
 rtl/npc_btb.sv | 112 +++++++++++
 1 files changed

// File: rtl/npc_btb.sv
// Next-PC generator: direct-mapped BTB with 2-bit counters, EX-stage
// mispredict correction and a pending redirect held across PC stalls.
module npc_btb #(
  parameter int ENTRIES = 8,
  localparam int IW = $clog2(ENTRIES),
  localparam int TW = 30 - IW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_hold,
  output logic [31:0] npc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_o
);

  logic          r_valid  [ENTRIES];
  logic [TW-1:0] r_tag    [ENTRIES];
  logic [31:0]   r_target [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];
  logic          r_pend_valid;
  logic [31:0]   r_pend_pc;

  logic [IW-1:0] w_lk_idx;
  logic          w_lk_hit;
  logic [IW-1:0] w_up_idx;
  logic [TW-1:0] w_up_tag;
  logic          w_up_tag_eq;
  logic          w_up_hit;
  logic [1:0]    w_ctr_inc;
  logic [1:0]    w_ctr_dec;
  logic          w_mp;
  logic [31:0]   w_cpc;
  logic          w_unused_bits;

  // Low PC bits never participate in index, tag or arithmetic.
  assign w_unused_bits = ^{pc_i[1:0], ex_pc[1:0]};

  assign w_lk_idx = pc_i[IW+1:2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == pc_i[31:IW+2]);

  assign pred_taken_o  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign pred_target_o = pred_taken_o ? r_target[w_lk_idx] : pc_i + 32'd4;

  assign w_up_idx    = ex_pc[IW+1:2];
  assign w_up_tag    = ex_pc[31:IW+2];
  assign w_up_tag_eq = (r_tag[w_up_idx] == w_up_tag);
  assign w_up_hit    = r_valid[w_up_idx] && w_up_tag_eq;
  assign w_ctr_inc   = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
  assign w_ctr_dec   = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;

  // A non-branch predicted taken means the BTB aliased onto a non-branch.
  assign w_mp = ex_valid &&
                ((ex_is_br && (ex_taken != ex_pred_taken)) ||
                 (ex_is_br && ex_taken && (ex_target != ex_pred_target)) ||
                 (!ex_is_br && ex_pred_taken));

  assign w_cpc = (ex_taken && ex_is_br) ? ex_target : ex_pc + 32'd4;

  assign redirect_o = w_mp;
  assign npc_o = w_mp         ? w_cpc :
                 r_pend_valid ? r_pend_pc :
                                pred_target_o;

  // BTB training from resolved EX instructions; runs regardless of PC stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (ex_valid) begin
      if (ex_is_br) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= ex_taken ? w_ctr_inc : w_ctr_dec;
          if (ex_taken) r_target[w_up_idx] <= ex_target;
        end else if (ex_taken) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= ex_target;
          r_ctr[w_up_idx]    <= 2'b10;
        end
      end else if (ex_pred_taken && w_up_tag_eq) begin
        r_valid[w_up_idx] <= 1'b0;
      end
    end
  end

  // Hold a correction that arrives while the PC register is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else if (w_mp && pc_hold) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= w_cpc;
    end else if (!pc_hold && !w_mp) begin
      r_pend_valid <= 1'b0;
    end
  end

endmodule
